// File: rtl/id_ex_register.sv
// ID/EX pipeline register: captures the decoded control word, operands, register
// numbers and PC+4 for EX, detects load-use hazards against the instruction in EX,
// inserts bubbles on flush/stall and keeps a saturating count of inserted bubbles.
module id_ex_register #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned CONTROL_SIZE = 8,
  parameter int unsigned MEMREAD_BIT  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [CONTROL_SIZE-1:0] controlIn,
  input  logic                    validIn,
  input  logic [DATA_WIDTH-1:0]   pcPlus4In,
  input  logic [DATA_WIDTH-1:0]   readData1In,
  input  logic [DATA_WIDTH-1:0]   readData2In,
  input  logic [DATA_WIDTH-1:0]   immIn,
  input  logic [4:0]              rsIn,
  input  logic [4:0]              rtIn,
  input  logic [4:0]              rdIn,
  input  logic                    flush,
  input  logic                    holdIn,
  output logic [CONTROL_SIZE-1:0] controlOut,
  output logic                    validOut,
  output logic [DATA_WIDTH-1:0]   pcPlus4Out,
  output logic [DATA_WIDTH-1:0]   readData1Out,
  output logic [DATA_WIDTH-1:0]   readData2Out,
  output logic [DATA_WIDTH-1:0]   immOut,
  output logic [4:0]              rsOut,
  output logic [4:0]              rtOut,
  output logic [4:0]              rdOut,
  output logic                    stallOut,
  output logic [15:0]             bubbleCount
);

  logic [CONTROL_SIZE-1:0] control_d, control_q;
  logic                    valid_d, valid_q;
  logic [DATA_WIDTH-1:0]   pc_plus4_d, pc_plus4_q;
  logic [DATA_WIDTH-1:0]   read_data1_d, read_data1_q;
  logic [DATA_WIDTH-1:0]   read_data2_d, read_data2_q;
  logic [DATA_WIDTH-1:0]   imm_d, imm_q;
  logic [4:0]              rs_d, rs_q;
  logic [4:0]              rt_d, rt_q;
  logic [4:0]              rd_d, rd_q;
  logic [15:0]             bubble_count_d, bubble_count_q;
  logic                    stall;
  logic                    insert_bubble;

  // Load-use hazard: a real load in EX whose nonzero destination (rt) feeds ID.
  always_comb begin
    stall = valid_q & control_q[MEMREAD_BIT] & (rt_q != 5'd0) & validIn &
            ((rt_q == rsIn) | (rt_q == rtIn));
  end

  // Next state: hold beats flush/stall bubble, which beats a normal load.
  always_comb begin
    control_d      = control_q;
    valid_d        = valid_q;
    pc_plus4_d     = pc_plus4_q;
    read_data1_d   = read_data1_q;
    read_data2_d   = read_data2_q;
    imm_d          = imm_q;
    rs_d           = rs_q;
    rt_d           = rt_q;
    rd_d           = rd_q;
    bubble_count_d = bubble_count_q;
    insert_bubble  = flush | stall;
    if (!holdIn) begin
      if (insert_bubble) begin
        control_d    = '0;
        valid_d      = 1'b0;
        pc_plus4_d   = '0;
        read_data1_d = '0;
        read_data2_d = '0;
        imm_d        = '0;
        rs_d         = '0;
        rt_d         = '0;
        rd_d         = '0;
        // Flush and stall together still count as a single bubble.
        if (bubble_count_q != 16'hFFFF) begin
          bubble_count_d = bubble_count_q + 16'd1;
        end
      end else begin
        control_d    = controlIn;
        valid_d      = validIn;
        pc_plus4_d   = pcPlus4In;
        read_data1_d = readData1In;
        read_data2_d = readData2In;
        imm_d        = immIn;
        rs_d         = rsIn;
        rt_d         = rtIn;
        rd_d         = rdIn;
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      control_q      <= '0;
      valid_q        <= 1'b0;
      pc_plus4_q     <= '0;
      read_data1_q   <= '0;
      read_data2_q   <= '0;
      imm_q          <= '0;
      rs_q           <= '0;
      rt_q           <= '0;
      rd_q           <= '0;
      bubble_count_q <= '0;
    end else begin
      control_q      <= control_d;
      valid_q        <= valid_d;
      pc_plus4_q     <= pc_plus4_d;
      read_data1_q   <= read_data1_d;
      read_data2_q   <= read_data2_d;
      imm_q          <= imm_d;
      rs_q           <= rs_d;
      rt_q           <= rt_d;
      rd_q           <= rd_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  // Drive outputs from the registered state.
  always_comb begin
    controlOut   = control_q;
    validOut     = valid_q;
    pcPlus4Out   = pc_plus4_q;
    readData1Out = read_data1_q;
    readData2Out = read_data2_q;
    immOut       = imm_q;
    rsOut        = rs_q;
    rtOut        = rt_q;
    rdOut        = rd_q;
    stallOut     = stall;
    bubbleCount  = bubble_count_q;
  end

endmodule

// File: tb/tb_id_ex_register.sv
// Self-checking bench for id_ex_register: a reference model pushes the expected
// EX state when inputs are driven; it is popped and compared after the clock edge.
module tb_id_ex_register;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  controlIn;
  logic        validIn;
  logic [31:0] pcPlus4In, readData1In, readData2In, immIn;
  logic [4:0]  rsIn, rtIn, rdIn;
  logic        flush, holdIn;
  logic [7:0]  controlOut;
  logic        validOut;
  logic [31:0] pcPlus4Out, readData1Out, readData2Out, immOut;
  logic [4:0]  rsOut, rtOut, rdOut;
  logic        stallOut;
  logic [15:0] bubbleCount;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] cnt;
  } exp_t;

  exp_t m;
  exp_t sb[$];

  always #5 clock = ~clock;

  id_ex_register dut (
    .clock        (clock),
    .reset        (reset),
    .controlIn    (controlIn),
    .validIn      (validIn),
    .pcPlus4In    (pcPlus4In),
    .readData1In  (readData1In),
    .readData2In  (readData2In),
    .immIn        (immIn),
    .rsIn         (rsIn),
    .rtIn         (rtIn),
    .rdIn         (rdIn),
    .flush        (flush),
    .holdIn       (holdIn),
    .controlOut   (controlOut),
    .validOut     (validOut),
    .pcPlus4Out   (pcPlus4Out),
    .readData1Out (readData1Out),
    .readData2Out (readData2Out),
    .immOut       (immOut),
    .rsOut        (rsOut),
    .rtOut        (rtOut),
    .rdOut        (rdOut),
    .stallOut     (stallOut),
    .bubbleCount  (bubbleCount)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are already driven; model one edge, push the expectation, then compare.
  task automatic step(input string tag, input bit cmp);
    logic stall_e;
    exp_t n, e;
    #1;
    stall_e = m.valid & m.ctrl[4] & (m.rt != 5'd0) & validIn &
              ((m.rt == rsIn) | (m.rt == rtIn));
    if (cmp && !reset) check({tag, "_stall"}, 64'(stallOut), 64'(stall_e));
    n = m;
    if (reset) begin
      n = '0;
    end else if (holdIn) begin
      n = m;
    end else if (flush || stall_e) begin
      n     = '0;
      n.cnt = (m.cnt == 16'hFFFF) ? m.cnt : m.cnt + 16'd1;
    end else begin
      n.ctrl  = controlIn;
      n.valid = validIn;
      n.pc    = pcPlus4In;
      n.r1    = readData1In;
      n.r2    = readData2In;
      n.imm   = immIn;
      n.rs    = rsIn;
      n.rt    = rtIn;
      n.rd    = rdIn;
    end
    sb.push_back(n);
    m = n;
    @(posedge clock);
    #1;
    e = sb.pop_front();
    if (cmp) begin
      check({tag, "_ctrl"},  64'(controlOut),   64'(e.ctrl));
      check({tag, "_valid"}, 64'(validOut),     64'(e.valid));
      check({tag, "_pc"},    64'(pcPlus4Out),   64'(e.pc));
      check({tag, "_rd1"},   64'(readData1Out), 64'(e.r1));
      check({tag, "_rd2"},   64'(readData2Out), 64'(e.r2));
      check({tag, "_imm"},   64'(immOut),       64'(e.imm));
      check({tag, "_regs"},  64'({rsOut, rtOut, rdOut}), 64'({e.rs, e.rt, e.rd}));
      check({tag, "_cnt"},   64'(bubbleCount),  64'(e.cnt));
    end
  endtask

  initial begin
    m           = '0;
    reset       = 1'b1;
    controlIn   = 8'hFF;
    validIn     = 1'b1;
    pcPlus4In   = 32'hDEAD_BEEF;
    readData1In = 32'h1111_1111;
    readData2In = 32'h2222_2222;
    immIn       = 32'hFFFF_FFF0;
    rsIn        = 5'd7;
    rtIn        = 5'd7;
    rdIn        = 5'd9;
    flush       = 1'b1;
    holdIn      = 1'b0;

    // Reset for two cycles with arbitrary inputs.
    @(negedge clock);
    step("rst0", 1'b1);
    step("rst1", 1'b1);
    check("rst_stall", 64'(stallOut), 64'd0);
    check("rst_cnt", 64'(bubbleCount), 64'd0);
    check("rst_valid", 64'(validOut), 64'd0);

    // Pass-through.
    reset       = 1'b0;
    flush       = 1'b0;
    controlIn   = 8'h21;
    pcPlus4In   = 32'h0000_0008;
    readData1In = 32'h5;
    readData2In = 32'h77;
    immIn       = 32'h1234;
    rsIn        = 5'd1;
    rtIn        = 5'd2;
    rdIn        = 5'd3;
    validIn     = 1'b1;
    step("pass", 1'b1);
    check("pass_ctrl", 64'(controlOut), 64'h21);
    check("pass_valid", 64'(validOut), 64'd1);
    check("pass_stall", 64'(stallOut), 64'd0);

    // Load-use: load with MemRead and rt=5, then a consumer reading r5 as rs.
    controlIn = 8'h10;
    rsIn      = 5'd6;
    rtIn      = 5'd5;
    rdIn      = 5'd0;
    step("ld", 1'b1);
    controlIn   = 8'h21;
    rsIn        = 5'd5;
    rtIn        = 5'd7;
    rdIn        = 5'd8;
    readData1In = 32'hAAAA;
    #1;
    check("lu_stall", 64'(stallOut), 64'd1);
    step("lu_bub", 1'b1);
    check("lu_bub_valid", 64'(validOut), 64'd0);
    check("lu_bub_ctrl", 64'(controlOut), 64'd0);
    check("lu_bub_cnt", 64'(bubbleCount), 64'd1);
    check("lu_bub_stall", 64'(stallOut), 64'd0);
    step("lu_load", 1'b1);
    check("lu_load_ctrl", 64'(controlOut), 64'h21);
    check("lu_load_rs", 64'(rsOut), 64'd5);
    check("lu_load_valid", 64'(validOut), 64'd1);

    // Zero register never hazards.
    controlIn = 8'h10;
    rsIn      = 5'd3;
    rtIn      = 5'd0;
    step("zld", 1'b1);
    controlIn = 8'h21;
    rsIn      = 5'd0;
    rtIn      = 5'd9;
    #1;
    check("zero_stall", 64'(stallOut), 64'd0);
    step("zuse", 1'b1);
    check("zero_valid", 64'(validOut), 64'd1);
    check("zero_cnt", 64'(bubbleCount), 64'd1);

    // Flush under hold is ignored, then takes effect once hold drops.
    flush  = 1'b1;
    holdIn = 1'b1;
    step("fhold", 1'b1);
    check("fhold_valid", 64'(validOut), 64'd1);
    check("fhold_ctrl", 64'(controlOut), 64'h21);
    check("fhold_cnt", 64'(bubbleCount), 64'd1);
    holdIn = 1'b0;
    step("flush", 1'b1);
    check("flush_valid", 64'(validOut), 64'd0);
    check("flush_cnt", 64'(bubbleCount), 64'd2);

    // Saturation: run flushes up to 16'hFFFE, then three more.
    repeat (int'(16'hFFFE - m.cnt)) step("pre", 1'b0);
    check("sat_pre", 64'(bubbleCount), 64'hFFFE);
    for (int i = 0; i < 3; i++) step("sat", 1'b1);
    check("sat_end", 64'(bubbleCount), 64'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_register.md
# id_ex_register

ID/EX pipeline register of the mips32 core, directly downstream of the unit control decoder. It captures the decoder's control word together with the ID-stage operands, register numbers and PC+4, and presents them to EX one cycle later. It also detects load-use hazards against the instruction currently in EX, stalling upstream and inserting a bubble. It honours a flush from branch resolution and a freeze from downstream, and counts inserted bubbles for performance monitoring.

## Interface
Parameters:
- DATA_WIDTH, 32, width of operands, immediate and PC+4
- CONTROL_SIZE, 8, width of the control word from unit control
- MEMREAD_BIT, 4, index of the MemRead bit in the control word

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- controlIn  in  CONTROL_SIZE  control word from unit control
- validIn  in  1  ID holds a real instruction
- pcPlus4In  in  DATA_WIDTH  PC+4 of the ID instruction
- readData1In, readData2In  in  DATA_WIDTH  register-file outputs for rs and rt
- immIn  in  DATA_WIDTH  sign-extended immediate
- rsIn, rtIn, rdIn  in  5  register numbers
- flush  in  1  taken branch/jump; kill the ID instruction
- holdIn  in  1  downstream busy; freeze this register
- controlOut  out  CONTROL_SIZE  registered control word
- validOut  out  1  EX holds a real instruction
- pcPlus4Out, readData1Out, readData2Out, immOut  out  DATA_WIDTH  registered copies
- rsOut, rtOut, rdOut  out  5  registered copies
- stallOut  out  1  load-use hazard; hold PC and IF/ID this cycle
- bubbleCount  out  16  saturating count of inserted bubbles

## Operation
- The control word is opaque except bit MEMREAD_BIT. No field is re-decoded.
- Hazard (combinational): stallOut = validOut & controlOut[MEMREAD_BIT] & (rtOut != 0) & validIn & ((rtOut == rsIn) | (rtOut == rtIn)).
- Per rising edge, actions in priority order:
  1. reset: every output register is cleared to 0, including bubbleCount.
  2. holdIn: all registers keep their values, and bubbleCount is unchanged.
  3. flush: the register loads a bubble.
  4. stallOut: the register loads a bubble.
  5. Otherwise (load): every *Out register takes its *In value, and validOut <= validIn.
- Bubble: controlOut, all data and register-number outputs are set to 0, and validOut is set to 0.
- bubbleCount increments by 1 on each edge that takes action 3 or 4. It saturates at 16'hFFFF and never wraps.
- When flush and stallOut are both active, the block inserts one bubble and counts it once.
- The block does not generate a stall for holdIn. Upstream receives holdIn directly.

## Timing
- Latency: 1 cycle from ID inputs to EX outputs.
- Reset value of every registered output is 0. After reset, stallOut is 0 because validOut is 0.
- stallOut is combinational. It is valid in the same cycle the ID inputs are presented, with no registered delay.
- A load-use stall lasts exactly one cycle. The bubble clears validOut, so stallOut deasserts on the next cycle and the stalled instruction then loads. This assumes the upstream holds its inputs stable during the stall.
- While holdIn=1, stallOut keeps being evaluated from the frozen EX state and the current ID inputs.
- If reset is asserted mid-stall or mid-hold, all state is cleared on that edge.
- A register number of 0 never causes a hazard.

## Test plan
- Reset: assert reset for 2 cycles with arbitrary inputs.
  - Required: all outputs are 0, stallOut=0, bubbleCount=0.
- Pass-through: controlIn=8'h21, pcPlus4In=32'h0000_0008, readData1In=32'h5, rs/rt/rd=1/2/3, validIn=1.
  - Required: the next cycle shows identical values on the outputs, validOut=1, stallOut=0.
- Load-use: load an instruction with controlIn bit4=1 and rtIn=5. Then present validIn=1, rsIn=5.
  - Required: stallOut=1 in that cycle.
  - Required: the next cycle has validOut=0, controlOut=0, bubbleCount=1, stallOut=0.
  - Required: the following cycle loads the held instruction.
- Zero register: repeat the load-use case with rtIn=0 loaded and rsIn=0 presented.
  - Required: stallOut stays 0 and no bubble is inserted.
- Flush with hold: first assert flush with holdIn=1.
  - Required: outputs and bubbleCount are unchanged.
  - Then release holdIn with flush=1. Required: validOut=0, bubbleCount increments by 1.
- Saturation: preload bubbleCount to 16'hFFFE, then apply 3 flush cycles.
  - Required: bubbleCount reads 16'hFFFF and stays there.
